// File: rtl/data_mem_responder.sv
// Data-port responder: byte-writable word RAM plus an MMIO window (LED, switches,
// optional timer/compare interrupt enabled by defining DMEM_TIMER_EN).
module data_mem_responder #(
  parameter int RAM_AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [3:0]  wen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        irq
);

  localparam int RAM_DEPTH = 1 << RAM_AW;

  localparam logic [15:0] OFF_LED     = 16'hF000;
  localparam logic [15:0] OFF_SW      = 16'hF004;
  localparam logic [15:0] OFF_TIMER   = 16'hF008;
  localparam logic [15:0] OFF_COMPARE = 16'hF00C;
  localparam logic [15:0] OFF_STATUS  = 16'hF010;

  logic              mmio_sel;
  logic              mmio_wr;
  logic [15:0]       mmio_off;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       ram_rdata;

  assign mmio_sel = (addr[31:16] == 16'hBFAF);
  assign mmio_wr  = mmio_sel && (wen == 4'b1111);
  assign mmio_off = addr[15:0];
  assign ram_idx  = addr[RAM_AW+1:2];

  // One byte-wide array per lane keeps each lane's write enable independent.
  // RAM writes are not gated by rst: contents survive reset and a store in the
  // reset cycle still lands.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [RAM_DEPTH];

      always_ff @(posedge clk) begin
        if (!mmio_sel && wen[gi]) begin
          mem[ram_idx] <= wdata[8*gi +: 8];
        end
      end

      assign ram_rdata[8*gi +: 8] = mem[ram_idx];
    end
  endgenerate

  logic [15:0] led_q, led_d;
  logic [15:0] sw_meta_q;
  logic [15:0] sw_sync_q;

  always_comb begin
    led_d = led_q;
    if (mmio_wr && mmio_off == OFF_LED) begin
      led_d = wdata[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q     <= 16'h0000;
      sw_meta_q <= 16'h0000;
      sw_sync_q <= 16'h0000;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= sw_in;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign led_out = led_q;

`ifdef DMEM_TIMER_EN
  logic [31:0] timer_q, timer_d;
  logic [31:0] compare_q, compare_d;
  logic        pending_q, pending_d;
  logic        enable_q, enable_d;
  logic        irq_q, irq_d;
  logic        match;
  logic        status_wr;

  assign match     = enable_q && (timer_q == compare_q);
  assign status_wr = mmio_wr && (mmio_off == OFF_STATUS);

  always_comb begin
    timer_d   = timer_q + 32'd1;
    compare_d = compare_q;
    enable_d  = enable_q;
    if (mmio_wr && mmio_off == OFF_TIMER) begin
      timer_d = wdata;
    end
    if (mmio_wr && mmio_off == OFF_COMPARE) begin
      compare_d = wdata;
    end
    if (status_wr) begin
      enable_d = wdata[1];
    end
    // A match in the same cycle as a W1C clear leaves pending set.
    pending_d = match | (pending_q & ~(status_wr & wdata[0]));
    irq_d     = pending_q & enable_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q   <= 32'h0000_0000;
      compare_q <= 32'hFFFF_FFFF;
      pending_q <= 1'b0;
      enable_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      compare_q <= compare_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata = 32'h0000_0000;
    if (mmio_sel) begin
      case (mmio_off)
        OFF_LED:     rdata = {16'h0000, led_q};
        OFF_SW:      rdata = {16'h0000, sw_sync_q};
`ifdef DMEM_TIMER_EN
        OFF_TIMER:   rdata = timer_q;
        OFF_COMPARE: rdata = compare_q;
        OFF_STATUS:  rdata = {30'd0, enable_q, pending_q};
`endif
        default:     rdata = 32'h0000_0000;
      endcase
    end else begin
      rdata = ram_rdata;
    end
  end

endmodule
